// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one registered-result ALU among NUM_REQ requesters
// Optional feature macro: ALU_ARB_DIV0_EN (trap DIV/DIVI by zero without issuing to the ALU).
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_op1,
  input  logic [NUM_REQ*DATA_W-1:0]  req_op2,
  input  logic [NUM_REQ*DATA_W-1:0]  req_imm,
  input  logic [NUM_REQ*PC_W-1:0]    req_pc,
  output logic                       alu_enable,
  output logic [INSTR_W-1:0]         alu_instr,
  output logic [DATA_W-1:0]          alu_op1,
  output logic [DATA_W-1:0]          alu_op2,
  output logic [DATA_W-1:0]          alu_imm,
  output logic [PC_W-1:0]            alu_pc,
  input  logic [DATA_W-1:0]          alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr, grant_id, pick_id;
  logic                pick_found;
  logic [INSTR_W-1:0]  pick_instr;
  logic [DATA_W-1:0]   pick_op1, pick_op2, pick_imm;
  logic [PC_W-1:0]     pick_pc;
  logic                pick_div0, trap_div0;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign pick_instr = req_instr[int'(pick_id)*INSTR_W +: INSTR_W];
  assign pick_op1   = req_op1[int'(pick_id)*DATA_W +: DATA_W];
  assign pick_op2   = req_op2[int'(pick_id)*DATA_W +: DATA_W];
  assign pick_imm   = req_imm[int'(pick_id)*DATA_W +: DATA_W];
  assign pick_pc    = req_pc[int'(pick_id)*PC_W +: PC_W];

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The alu_* registers double as the capture registers, so they hold between issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      req_ready  <= '0;
      alu_enable <= 1'b0;
      alu_instr  <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_imm    <= '0;
      alu_pc     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      req_ready  <= '0;
      alu_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id   <= pick_id;
            rr_ptr     <= (pick_id == ID_W'(NUM_REQ-1)) ? '0 : pick_id + 1'b1;
            req_ready  <= NUM_REQ'(1) << pick_id;
            alu_enable <= !pick_div0;
            alu_instr  <= pick_instr;
            alu_op1    <= pick_op1;
            alu_op2    <= pick_op2;
            alu_imm    <= pick_imm;
            alu_pc     <= pick_pc;
          end
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_id    <= grant_id;
          rsp_data  <= trap_div0 ? '1 : alu_result;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_DIV0_EN
  localparam logic [INSTR_W-1:0] OP_DIV  = INSTR_W'(4);
  localparam logic [INSTR_W-1:0] OP_DIVI = INSTR_W'(5);

  logic div0_q, rsp_err_q;

  assign pick_div0 = ((pick_instr == OP_DIV)  && (pick_op2 == '0)) ||
                     ((pick_instr == OP_DIVI) && (pick_imm == '0));
  assign trap_div0 = div0_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div0_q    <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == IDLE && pick_found) div0_q <= pick_div0;
      if (state == CAPTURE)                         rsp_err_q <= div0_q;
      else if (state == RESP && rsp_valid && rsp_ready) rsp_err_q <= 1'b0;
    end
  end
`else
  assign pick_div0 = 1'b0;
  assign trap_div0 = 1'b0;
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural 1-cycle ALU
module tb_alu_share_arbiter;
  localparam int NUM_REQ = 4, ID_W = 2, DATA_W = 32, PC_W = 32, INSTR_W = 5;
  localparam logic [4:0] I_ADD = 5'd0, I_SUB = 5'd1, I_ADDI = 5'd2, I_JAL = 5'd3, I_DIV = 5'd4, I_DIVI = 5'd5;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*INSTR_W-1:0] req_instr = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_op1 = '0, req_op2 = '0, req_imm = '0;
  logic [NUM_REQ*PC_W-1:0]    req_pc = '0;
  logic                       alu_enable;
  logic [INSTR_W-1:0]         alu_instr;
  logic [DATA_W-1:0]          alu_op1, alu_op2, alu_imm;
  logic [PC_W-1:0]            alu_pc;
  logic [DATA_W-1:0]          alu_result = '0;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b1;
  logic [ID_W-1:0]            rsp_id;
  logic [DATA_W-1:0]          rsp_data;
  logic                       rsp_err;
  logic                       busy;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   alu_en_cnt = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .PC_W(PC_W), .INSTR_W(INSTR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_op1(req_op1), .req_op2(req_op2), .req_imm(req_imm), .req_pc(req_pc),
    .alu_enable(alu_enable), .alu_instr(alu_instr), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [31:0] alu_f(input logic [4:0] i, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] imm, input logic [31:0] pc);
    case (i)
      I_ADD:   return a + b;
      I_SUB:   return a - b;
      I_ADDI:  return a + imm;
      I_JAL:   return pc + imm;
      I_DIV:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      I_DIVI:  return (imm == 0) ? 32'hFFFF_FFFF : a / imm;
      default: return 32'h0;
    endcase
  endfunction

  // Shared ALU: registered result, updates only when enabled.
  always @(posedge clk) begin
    if (alu_enable) begin
      alu_result <= alu_f(alu_instr, alu_op1, alu_op2, alu_imm, alu_pc);
      alu_en_cnt <= alu_en_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] d, input logic e);
    exp_t x;
    x.id   = ID_W'(id);
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Monitor: every completed response handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_id), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [4:0] instr, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc);
    req_instr[i*INSTR_W +: INSTR_W] = instr;
    req_op1[i*DATA_W +: DATA_W] = a;
    req_op2[i*DATA_W +: DATA_W] = b;
    req_imm[i*DATA_W +: DATA_W] = imm;
    req_pc[i*PC_W +: PC_W] = pc;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!rsp_valid && n < 20);
    chk("rsp_wait_timeout", 32'(rsp_valid), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, cnt0;

    // Reset state and single-op latency
    do_reset();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_alu_enable", 32'(alu_enable), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_alu_op1", alu_op1, 32'h0);
    cnt0 = alu_en_cnt;
    set_req(0, I_ADD, 5, 7, 0, 0);
    push(0, 12, 1'b0);
    req_valid = 4'b0001;
    cyc();
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    chk("t1_alu_enable", 32'(alu_enable), 32'h1);
    chk("t1_alu_op1", alu_op1, 32'd5);
    chk("t1_alu_op2", alu_op2, 32'd7);
    req_valid = '0;
    cyc();
    chk("t1_ready_pulse", 32'(req_ready), 32'h0);
    chk("t1_alu_enable_off", 32'(alu_enable), 32'h0);
    chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
    cyc();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    cyc();
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_alu_en_count", 32'(alu_en_cnt - cnt0), 32'h1);

    // Fairness and throughput with all requesters valid
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, I_ADDI, i, 0, 100, 0);
    push(0, 100, 1'b0); push(1, 101, 1'b0); push(2, 102, 1'b0); push(3, 103, 1'b0); push(0, 100, 1'b0);
    req_valid = 4'b1111;
    wait_rsp(n);
    chk("t2_first_latency", 32'(n), 32'd3);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(n);
      chk("t2_rsp_gap", 32'(n), 32'd4);
    end
    req_valid = '0;
    cyc();
    cyc();
    chk("t2_idle", 32'(busy), 32'h0);

    // Response backpressure
    do_reset();
    rsp_ready = 1'b0;
    set_req(1, I_SUB, 10, 3, 0, 0);
    push(1, 7, 1'b0);
    req_valid = 4'b0010;
    cyc();
    chk("t3_req_ready", 32'(req_ready), 32'h2);
    req_valid = '0;
    wait_rsp(n);
    set_req(2, I_ADD, 1, 1, 0, 0);
    push(2, 2, 1'b0);
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(rsp_valid), 32'h1);
      chk("t3_hold_data", rsp_data, 32'd7);
      chk("t3_hold_id", 32'(rsp_id), 32'd1);
      chk("t3_hold_busy", 32'(busy), 32'h1);
      chk("t3_no_grant", 32'(req_ready), 32'h0);
      if (k < 4) cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    chk("t3_idle_after_ready", 32'(busy), 32'h0);
    chk("t3_rsp_cleared", 32'(rsp_valid), 32'h0);
    cyc();
    chk("t3_late_grant", 32'(req_ready), 32'h4);
    req_valid = '0;
    wait_rsp(n);
    cyc();

    // Reset during CAPTURE abandons the op and clears rr_ptr
    do_reset();
    set_req(1, I_ADD, 50, 50, 0, 0);
    req_valid = 4'b0010;
    cyc();
    chk("t4_req_ready", 32'(req_ready), 32'h2);
    req_valid = '0;
    cyc();
    reset = 1'b1;
    cyc();
    chk("t4_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    set_req(1, I_ADD, 1, 2, 0, 0);
    set_req(3, I_ADD, 3, 4, 0, 0);
    push(1, 3, 1'b0);
    req_valid = 4'b1010;
    cyc();
    chk("t4_rr_ptr_cleared", 32'(req_ready), 32'h2);
    req_valid = '0;
    wait_rsp(n);
    cyc();
    set_req(2, I_ADD, 20, 22, 0, 0);
    push(2, 42, 1'b0);
    req_valid = 4'b0100;
    cyc();
    chk("t4_grant2", 32'(req_ready), 32'h4);
    req_valid = '0;
    wait_rsp(n);
    cyc();

    // Requester 3 granted twice in a row through the wrap
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_req(3, I_JAL, 0, 0, 8, 32'h40);
      push(3, 32'h48, 1'b0);
      req_valid = 4'b1000;
      cyc();
      chk("t5_grant3", 32'(req_ready), 32'h8);
      req_valid = '0;
      wait_rsp(n);
      cyc();
    end

    // Divide by zero
    do_reset();
    cnt0 = alu_en_cnt;
    set_req(0, I_DIV, 9, 0, 0, 0);
`ifdef ALU_ARB_DIV0_EN
    push(0, 32'hFFFF_FFFF, 1'b1);
`else
    push(0, 32'hFFFF_FFFF, 1'b0);
`endif
    req_valid = 4'b0001;
    cyc();
    chk("t6_req_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    wait_rsp(n);
    chk("t6_latency", 32'(n), 32'd2);
`ifdef ALU_ARB_DIV0_EN
    chk("t6_alu_not_enabled", 32'(alu_en_cnt - cnt0), 32'h0);
`else
    chk("t6_alu_enabled", 32'(alu_en_cnt - cnt0), 32'h1);
`endif
    cyc();
    chk("t6_err_cleared", 32'(rsp_err), 32'h0);
    cnt0 = alu_en_cnt;
    set_req(0, I_DIV, 9, 3, 0, 0);
    push(0, 3, 1'b0);
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    wait_rsp(n);
    chk("t6_div_enabled", 32'(alu_en_cnt - cnt0), 32'h1);
    cyc();

    repeat (3) cyc();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one registered-result ALU (1-cycle latency, enable-gated) among NUM_REQ requesters, e.g. lanes of a lock-in compute unit.
- Accepts one operation at a time, drives the ALU enable and operands for exactly one cycle, captures the result and returns it to the granted requester with a valid/ready response handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester index, equals clog2(NUM_REQ)
- DATA_W, 32, operand/result width, matches data_t
- PC_W, 32, pc width, matches instruction_memory_address_t
- INSTR_W, 5, width of alu_instruction_t encoding

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- req_instr  in  NUM_REQ*INSTR_W  flattened opcodes; slice i belongs to requester i
- req_op1  in  NUM_REQ*DATA_W  flattened operand 1
- req_op2  in  NUM_REQ*DATA_W  flattened operand 2
- req_imm  in  NUM_REQ*DATA_W  flattened immediate
- req_pc  in  NUM_REQ*PC_W  flattened pc
- alu_enable  out  1  ALU enable
- alu_instr  out  INSTR_W  to ALU instruction
- alu_op1, alu_op2, alu_imm  out  DATA_W each  to ALU
- alu_pc  out  PC_W  to ALU
- alu_result  in  DATA_W  ALU Result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  ID_W  index of the requester the response belongs to
- rsp_data  out  DATA_W  result
- rsp_err  out  1  error flag; always 0 unless ALU_ARB_DIV0_EN
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset clears all registers and outputs to 0: state=IDLE, rr_ptr=0, req_ready=0, rsp_*=0, alu_* =0. Reset mid-operation abandons the in-flight operation; no response is issued for it.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any req_valid is set, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ. Register its index into grant_id and latch its instr/op1/op2/imm/pc into capture registers. Go to ISSUE. rr_ptr <= (grant_id+1) mod NUM_REQ.
- req_ready[grant_id] is a registered pulse, high only during the ISSUE cycle. Requesters hold their request fields stable until they see req_ready.
- ISSUE: alu_enable=1; alu_* driven from the capture registers. Go to CAPTURE.
- CAPTURE: alu_result is valid. Register it into rsp_data, set rsp_valid=1 and rsp_id=grant_id. Go to RESP.
- RESP: hold rsp_valid, rsp_id and rsp_data stable until rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- A new grant can be made in the IDLE cycle that follows.
- alu_enable is 0 in every state except ISSUE. alu_* operand outputs hold their last value outside ISSUE.
- Latency: requests first seen in IDLE at cycle T give req_ready at T+1 and rsp_valid at T+3. Back-to-back throughput is one op per 4 cycles with rsp_ready tied high.
- Requests raised while busy are ignored until IDLE; no queuing.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- rsp_ready asserted without rsp_valid has no effect.

Optional Feature:
- Macro ALU_ARB_DIV0_EN.
- Defined: in IDLE, a granted DIV with op2==0 or DIVI with imm==0 is not issued to the ALU.
  - Sequence: IDLE -> ISSUE with alu_enable forced 0 -> CAPTURE.
  - In CAPTURE, rsp_data=all-ones and rsp_err=1. Same cycle timing as a normal op, and req_ready is still pulsed.
  - rsp_err is cleared on handshake.
- Undefined: no check; every op goes to the ALU, and rsp_err is tied 0.

Test Plan:
- Reset, then req_valid=4'b0001, ADD op1=5, op2=7 -> req_ready=0001 at T+1; alu_enable for 1 cycle at T+1; rsp_valid at T+3 with rsp_id=0, rsp_data=12.
- All four requesters valid continuously, rsp_ready=1, each op ADDI op1=i imm=100 -> grants in order 0,1,2,3,0; rsp_data 100,101,102,103,100; exactly 4 cycles between rsp_valid pulses.
- rsp_ready held 0 for 5 cycles after rsp_valid (SUB 10-3) -> rsp_data=7 and rsp_id stable all 5 cycles; no new req_ready and busy=1 throughout; returns to IDLE one cycle after rsp_ready=1.
- Reset asserted during CAPTURE -> next cycle rsp_valid=0, busy=0, rr_ptr=0; a subsequent request from requester 2 is granted normally.
- Requester 3 valid alone after a grant to 3 -> granted again (wrap search); JAL pc=0x40 imm=8 -> rsp_data=0x48.
- With ALU_ARB_DIV0_EN: DIV op1=9, op2=0 -> alu_enable never high, rsp_data=0xFFFFFFFF, rsp_err=1. Then DIV 9/3 -> rsp_data=3, rsp_err=0.
